exec_muldiv: RTL and testbench

EXEC_MULDIV -- requirements
Module: exec_muldiv

---
 rtl/exec_muldiv.sv | 148 ++++++++++++++
 tb/tb_exec_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exec_muldiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle shift-add multiply and restoring divide.
// Define EXEC_MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier instead.
module exec_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_m, r_a, r_hi, r_lo, r_out;
  logic             r_negq, r_negr, r_dz, r_vld;

  // Signed ops (MULT, DIV) have op[0]==0; work on magnitudes and fix signs at the end.
  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  assign w_sa    = ~in_op[0] & in_a[WIDTH-1];
  assign w_sb    = ~in_op[0] & in_b[WIDTH-1];
  assign w_abs_a = w_sa ? -in_a : in_a;
  assign w_abs_b = w_sb ? -in_b : in_b;

  // Multiply step: r_p = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_prod;
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};
  assign w_prod     = r_negq ? -w_mul_next : w_mul_next;

  // Restoring divide step: r_p = {remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]     w_rem_sh, w_rem_new;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_q, w_r;
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_m};
  assign w_rem_new  = w_ge ? w_rem_sh - {1'b0, r_m} : w_rem_sh;
  assign w_div_next = {w_rem_new[WIDTH-1:0], r_p[WIDTH-2:0], w_ge};
  assign w_q = r_dz ? '1  : (r_negq ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0]);
  assign w_r = r_dz ? r_a : (r_negr ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH]);

`ifdef EXEC_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fmag, w_fprod;
  assign w_fmag  = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
  assign w_fprod = (w_sa ^ w_sb) ? -w_fmag : w_fmag;
`endif

  assign in_ready  = (r_state == IDLE) & ~flush;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_vld;
  assign out_data  = r_out;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_out   <= '0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dz    <= 1'b0;
      r_vld   <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_cnt  <= '0;
          r_negq <= w_sa ^ w_sb;
          r_negr <= w_sa;
          r_dz   <= (in_b == '0);
          r_a    <= in_a;
          r_m    <= in_op[1] ? w_abs_b : w_abs_a;
          r_p    <= {{WIDTH{1'b0}}, (in_op[1] ? w_abs_a : w_abs_b)};
          case (in_op)
`ifdef EXEC_MULDIV_FAST_MUL_EN
            3'd0, 3'd1: begin
              {r_hi, r_lo} <= w_fprod;
              r_out   <= w_fprod[WIDTH-1:0];
              r_vld   <= 1'b1;
              r_state <= DONE;
            end
`else
            3'd0, 3'd1: r_state <= MUL;
`endif
            3'd2, 3'd3: r_state <= DIV;
            3'd4: begin r_out <= r_hi; r_vld <= 1'b1; r_state <= DONE; end
            3'd5: begin r_out <= r_lo; r_vld <= 1'b1; r_state <= DONE; end
            3'd6: begin r_hi <= in_a; r_out <= in_a; r_vld <= 1'b1; r_state <= DONE; end
            default: begin r_lo <= in_a; r_out <= in_a; r_vld <= 1'b1; r_state <= DONE; end
          endcase
        end
        MUL: begin
          r_p   <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            {r_hi, r_lo} <= w_prod;
            r_out   <= w_prod[WIDTH-1:0];
            r_vld   <= 1'b1;
            r_cnt   <= '0;
            r_state <= DONE;
          end
        end
        DIV: begin
          r_p   <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_lo    <= w_q;
            r_hi    <= w_r;
            r_out   <= w_q;
            r_vld   <= 1'b1;
            r_cnt   <= '0;
            r_state <= DONE;
          end
        end
        default: if (out_ready) begin
          r_vld   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exec_muldiv.sv
// Vector table plus hand sequences (flush, stall, reset, no-bypass) for exec_muldiv, WIDTH=32.
module tb_exec_muldiv;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0, in_b = '0, out_data, hi, lo;

  exec_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .hi(hi), .lo(lo), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo, out;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo, out;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  // Edges from the accepting edge up to the first edge that samples out_valid high.
  function automatic int exp_lat(input logic [2:0] op);
    if (op >= 3'd4) return 1;
`ifdef EXEC_MULDIV_FAST_MUL_EN
    if (op < 3'd2) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] eout,
                        input int stall, input string nm);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back('{ehi, elo, eout, exp_lat(op)});
    @(posedge clk);
    #1 in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    lat = 0; got = 0;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
    end
    e = sb.pop_front();
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no out_valid within %0d edges, expected %0d", nm, lat, e.lat);
      return;
    end
    chk({nm, " latency"}, 64'(lat), 64'(e.lat));
    chk({nm, " out_data"}, 64'(out_data), 64'(e.out));
    chk({nm, " hi"}, 64'(hi), 64'(e.hi));
    chk({nm, " lo"}, 64'(lo), 64'(e.lo));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({nm, " stall out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " stall out_data"}, 64'(out_data), 64'(e.out));
      chk({nm, " stall in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " idle after handshake"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  vec_t vt[$];
  int   seen;

  initial begin
    vt.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, "MULTU max"});
    vt.push_back('{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFF1, "MULT -3*5"});
    vt.push_back('{3'd0, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFE, "MULT maxpos*2"});
    vt.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000001, "MULT -1*-1"});
    vt.push_back('{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00000000, "MULTU 2^32"});
    vt.push_back('{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, "DIV -7/2"});
    vt.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h80000000, "DIV minneg/-1"});
    vt.push_back('{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, "DIVU 5/0"});
    vt.push_back('{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFF, "DIV -5/0"});
    vt.push_back('{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 32'h0000000E, "DIVU 100/7"});
    vt.push_back('{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, "DIVU max/1"});
    vt.push_back('{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFD, "DIV 7/-2"});
    vt.push_back('{3'd7, 32'h0000ABCD, 32'h0, 32'h00000001, 32'h0000ABCD, 32'h0000ABCD, "MTLO"});
    vt.push_back('{3'd5, 32'h0, 32'h0, 32'h00000001, 32'h0000ABCD, 32'h0000ABCD, "MFLO"});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);

    foreach (vt[i])
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].out, 0, vt[i].name);

    // Flush in the 10th DIV cycle must leave HI/LO untouched and produce no result.
    run_op(3'd6, 32'h11, 32'h0, 32'h11, 32'h0000ABCD, 32'h11, 0, "MTHI 11");
    run_op(3'd7, 32'h22, 32'h0, 32'h11, 32'h22, 32'h22, 0, "MTLO 22");
    @(negedge clk);
    in_op = 3'd2; in_a = 32'h64; in_b = 32'h7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    chk("flush in_ready low", 64'(in_ready), 64'd0);
    chk("flush busy before", 64'(busy), 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush hi", 64'(hi), 64'h11);
    chk("flush lo", 64'(lo), 64'h22);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush no result", 64'(seen), 64'd0);

    // Stalled MTHI then MFHI.
    run_op(3'd6, 32'h1234, 32'h0, 32'h1234, 32'h22, 32'h1234, 5, "MTHI stall");
    run_op(3'd4, 32'h0, 32'h0, 32'h1234, 32'h22, 32'h1234, 0, "MFHI");

    // Handshake edge with a new request pending must not accept it.
    @(negedge clk);
    in_op = 3'd7; in_a = 32'h55; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("nobypass first accept", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("nobypass idle", {62'd0, busy, out_valid}, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("nobypass second accept", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset in the middle of a MULT.
    @(negedge clk);
    in_op = 3'd0; in_a = 32'h3; in_b = 32'h4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    chk("midreset out_data", 64'(out_data), 64'd0);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset in_ready", 64'(in_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
